map_reader: RTL and testbench

- Read-side counterpart to the tile-map writer. Takes the 300-entry tile map (20 cols x 15 rows, 32x32-pixel tiles) and serves per-pixel tile lookups to the VGA renderer.
- Holds a shadow copy of the map. The copy is refreshed one entry per clock during vertical blanking, so player edits made mid-frame never tear the picture.
- Sits between the map writer and the colour mapper. The pixel coordinates come from the VGA controller.

---
 rtl/map_pkg.sv | 43 ++++
 rtl/map_idx_calc.sv | 27 ++
 rtl/map_reader.sv | 113 +++++++++++
 tb/tb_map_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared tile-map geometry, tile codes and lookup types for the map reader
// and the player-collision logic.
package map_pkg;

    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int MAP_SIZE   = MAP_COLS * MAP_ROWS;
    localparam int TILE_SHIFT = 5;
    localparam int CODE_W     = 3;
    localparam int COORD_W    = 10;
    localparam int OFF_W      = TILE_SHIFT;
    localparam int IDX_W      = 9;
    localparam int X_LIMIT    = MAP_COLS << TILE_SHIFT;
    localparam int Y_LIMIT    = MAP_ROWS << TILE_SHIFT;

    typedef logic [CODE_W-1:0] tile_code_t;
    typedef logic [IDX_W-1:0]  map_idx_t;

    typedef enum tile_code_t {
        FLOOR = 3'd0,
        WALL  = 3'd1,
        BRICK = 3'd2,
        GOAL1 = 3'd3,
        GOAL2 = 3'd4,
        STEEL = 3'd5,
        WATER = 3'd6
    } tile_e;

    localparam tile_code_t TILE_OOR = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } copy_state_e;

    typedef struct packed {
        map_idx_t         idx;
        logic             in_range;
        logic [OFF_W-1:0] xoff;
        logic [OFF_W-1:0] yoff;
    } lookup_t;

endpackage

// File: rtl/map_idx_calc.sv
// Pixel coordinate to tile index: row*20 + col as a shift-add, plus the
// visible-area flag and the in-tile pixel offsets.
module map_idx_calc
    import map_pkg::*;
(
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    output map_idx_t           idx_o,
    output logic               in_range_o,
    output logic [OFF_W-1:0]   xoff_o,
    output logic [OFF_W-1:0]   yoff_o
);

    logic [4:0] col;
    logic [3:0] row;
    map_idx_t   row_w;

    assign col   = draw_x_i[COORD_W-1:TILE_SHIFT];
    assign row   = draw_y_i[TILE_SHIFT+3:TILE_SHIFT];
    assign row_w = {5'b0, row};

    assign idx_o      = (row_w << 4) + (row_w << 2) + {4'b0, col};
    assign in_range_o = (draw_x_i < COORD_W'(X_LIMIT)) && (draw_y_i < COORD_W'(Y_LIMIT));
    assign xoff_o     = draw_x_i[OFF_W-1:0];
    assign yoff_o     = draw_y_i[OFF_W-1:0];

endmodule

// File: rtl/map_reader.sv
// Tile-map reader: two-stage per-pixel tile lookup for the VGA renderer.
// Define MAP_READER_SNAPSHOT_EN to read from a shadow copy refreshed in vblank.
module map_reader
    import map_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  int                 map_in [MAP_SIZE],
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output tile_code_t         tile_code,
    output logic [OFF_W-1:0]   tile_xoff,
    output logic [OFF_W-1:0]   tile_yoff,
    output logic               out_valid,
    output logic               copy_busy,
    output logic               copy_done
);

    lookup_t    lookup_d;
    lookup_t    s1_q;
    logic       s1_valid_q;
    tile_code_t rd_code;

    map_idx_calc u_idx_calc (
        .draw_x_i   (DrawX),
        .draw_y_i   (DrawY),
        .idx_o      (lookup_d.idx),
        .in_range_o (lookup_d.in_range),
        .xoff_o     (lookup_d.xoff),
        .yoff_o     (lookup_d.yoff)
    );

`ifdef MAP_READER_SNAPSHOT_EN
    tile_code_t  shadow_q [MAP_SIZE];
    copy_state_e state_q;
    map_idx_t    copy_idx_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            copy_idx_q <= '0;
            copy_busy  <= 1'b0;
            copy_done  <= 1'b0;
            // NOTE: the shadow must come up all-FLOOR, so this array is a register file with reset, not a RAM.
            for (int i = 0; i < MAP_SIZE; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            copy_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q    <= COPY;
                        copy_idx_q <= '0;
                        copy_busy  <= 1'b1;
                    end
                end
                COPY: begin
                    shadow_q[copy_idx_q] <= map_in[copy_idx_q][CODE_W-1:0];
                    if (copy_idx_q == map_idx_t'(MAP_SIZE - 1)) begin
                        state_q   <= IDLE;
                        copy_busy <= 1'b0;
                        copy_done <= 1'b1;
                    end else begin
                        copy_idx_q <= copy_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: non-blocking shadow writes give read-before-write when a lookup hits the entry being copied.
    assign rd_code = shadow_q[s1_q.idx];
`else
    assign rd_code   = map_in[s1_q.idx][CODE_W-1:0];
    assign copy_busy = 1'b0;
    assign copy_done = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            tile_code  <= '0;
            tile_xoff  <= '0;
            tile_yoff  <= '0;
            out_valid  <= 1'b0;
        end else begin
            s1_q       <= lookup_d;
            s1_valid_q <= pix_valid;
            tile_code  <= s1_q.in_range ? rd_code : TILE_OOR;
            tile_xoff  <= s1_q.xoff;
            tile_yoff  <= s1_q.yoff;
            out_valid  <= s1_valid_q;
        end
    end

    // Only the low CODE_W bits of each map word carry a tile code.
    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < MAP_SIZE; i++) begin
            unused_bits = unused_bits ^ (^map_in[i][31:CODE_W]);
        end
`ifndef MAP_READER_SNAPSHOT_EN
        unused_bits = unused_bits ^ frame_start;
`endif
    end

endmodule

// File: tb/tb_map_reader.sv
// Self-checking bench for map_reader: directed steps plus random lookups
// against a coordinate-level tile-map model; tracks the snapshot in either build.
module tb_map_reader;
    import map_pkg::*;

`ifdef MAP_READER_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    int         map_in [300];
    logic       frame_start, pix_valid;
    logic [9:0] DrawX, DrawY;
    tile_code_t tile_code;
    logic [4:0] tile_xoff, tile_yoff;
    logic       out_valid, copy_busy, copy_done;

    int checks = 0;
    int errors = 0;
    int shadow [300];

    typedef struct {
        bit valid;
        bit known;
        int code;
        int xoff;
        int yoff;
        int x;
        int y;
    } exp_t;
    exp_t pipe [$];

    map_reader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .map_in      (map_in),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .tile_code   (tile_code),
        .tile_xoff   (tile_xoff),
        .tile_yoff   (tile_yoff),
        .out_valid   (out_valid),
        .copy_busy   (copy_busy),
        .copy_done   (copy_done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Tile the renderer should see at (x, y): off-screen is 7, otherwise the
    // map the lookup path reads (snapshot or live map).
    function automatic int model_code(input int x, input int y);
        int idx;
        if (x >= 640 || y >= 480) return 7;
        idx = (y / 32) * 20 + (x / 32);
        return SNAP ? shadow[idx] : (map_in[idx] & 7);
    endfunction

    function automatic exp_t make_exp(input bit v, input int x, input int y, input bit known);
        exp_t e;
        e.valid = v;
        e.xoff  = x % 32;
        e.yoff  = y % 32;
        e.x     = x;
        e.y     = y;
        e.known = known || x >= 640 || y >= 480;
        e.code  = model_code(x, y);
        return e;
    endfunction

    task automatic step(input logic fs, input logic v, input int x, input int y, input bit known);
        exp_t e;
        @(posedge Clk);
        #1;
        if (pipe.size() == 2) begin
            e = pipe.pop_front();
            check($sformatf("out_valid(%0d,%0d)", e.x, e.y), {31'b0, out_valid}, {31'b0, e.valid});
            check($sformatf("tile_xoff(%0d,%0d)", e.x, e.y), {27'b0, tile_xoff}, e.xoff);
            check($sformatf("tile_yoff(%0d,%0d)", e.x, e.y), {27'b0, tile_yoff}, e.yoff);
            if (e.known)
                check($sformatf("tile_code(%0d,%0d)", e.x, e.y), {29'b0, tile_code}, e.code);
        end
        frame_start = fs;
        pix_valid   = v;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        pipe.push_back(make_exp(v, x, y, known));
    endtask

    task automatic lookup(input int x, input int y);
        step(1'b0, 1'b1, x, y, 1'b1);
    endtask

    // Two off-screen idle steps: everything in flight is map-independent.
    task automatic flush();
        step(1'b0, 1'b0, 700, 0, 1'b1);
        step(1'b0, 1'b0, 700, 0, 1'b1);
    endtask

    task automatic random_lookups(input int n, input bit known);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), known);
    endtask

    // Idle inputs during reset; expectations restart from the cleared pipeline.
    task automatic apply_reset_inputs();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
    endtask

    task automatic restart_pipe();
        exp_t z;
        z = make_exp(1'b0, 0, 0, 1'b0);
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(make_exp(1'b0, 0, 0, 1'b1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tile_code"}, {29'b0, tile_code}, 0);
        check({tag, ".tile_xoff"}, {27'b0, tile_xoff}, 0);
        check({tag, ".tile_yoff"}, {27'b0, tile_yoff}, 0);
        check({tag, ".out_valid"}, {31'b0, out_valid}, 0);
        check({tag, ".copy_busy"}, {31'b0, copy_busy}, 0);
        check({tag, ".copy_done"}, {31'b0, copy_done}, 0);
    endtask

    // Pulse frame_start, then watch 320 cycles. refire_at re-pulses
    // frame_start mid-copy; reset_at asserts Reset at that copy cycle.
    task automatic run_copy(input string tag, input int refire_at, input int reset_at);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = -1;
        int exp_busy, exp_done, exp_at;
        step(1'b1, 1'b0, 700, 0, 1'b1);
        for (int c = 1; c <= 320; c++) begin
            if (c == reset_at) begin
                @(posedge Clk);
                #1;
                Reset = 1'b1;
                apply_reset_inputs();
                #1;
                check_all_zero({tag, ".midreset"});
                @(negedge Clk);
                Reset = 1'b0;
                for (int i = 0; i < 300; i++) shadow[i] = 0;
                restart_pipe();
            end
            step(1'(c == refire_at), 1'($urandom), int'($urandom_range(0, 799)),
                 int'($urandom_range(0, 524)), 1'b0);
            if (copy_busy === 1'b1) busy_n++;
            if (copy_done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        if (reset_at > 0) begin
            exp_busy = SNAP ? reset_at - 1 : 0;
            exp_done = 0;
            exp_at   = -1;
        end else begin
            exp_busy = SNAP ? 300 : 0;
            exp_done = SNAP ? 1 : 0;
            exp_at   = SNAP ? 301 : -1;
            for (int i = 0; i < 300; i++) shadow[i] = map_in[i] & 7;
        end
        check({tag, ".busy_cycles"}, busy_n, exp_busy);
        check({tag, ".done_pulses"}, done_n, exp_done);
        check({tag, ".done_cycle"}, done_at, exp_at);
    endtask

    initial begin
        for (int i = 0; i < 300; i++) begin
            map_in[i] = i % 7;
            shadow[i] = 0;
        end
        apply_reset_inputs();
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        restart_pipe();

        // Before any snapshot the shadow is all FLOOR.
        lookup(64, 32);
        lookup(639, 479);
        flush();

        run_copy("snap1", -1, -1);
        lookup(64, 32);
        flush();

        // Back-to-back lookups along the top row.
        lookup(0, 0);
        lookup(32, 0);
        lookup(64, 0);
        flush();

        // Visible-area edges and off-screen coordinates.
        lookup(700, 10);
        lookup(639, 479);
        lookup(640, 0);
        lookup(0, 480);
        lookup(1023, 1023);
        lookup(5, 1000);
        lookup(31, 31);
        flush();

        for (int i = 0; i < 300; i++) map_in[i] = int'($urandom);
        map_in[22] = int'(($urandom & ~32'd7) | 32'd2);
        flush();
        run_copy("snap2", -1, -1);
        random_lookups(200, 1'b1);
        flush();

        // Edit after the snapshot: hidden until the next frame_start when snapshotting.
        map_in[22] = int'($urandom & ~32'd7);
        lookup(71, 35);
        lookup(64, 32);
        flush();

        run_copy("snap3", 100, -1);
        lookup(64, 32);
        random_lookups(50, 1'b1);
        flush();

        for (int i = 0; i < 300; i++) map_in[i] = int'($urandom);
        flush();
        run_copy("abort", -1, 150);
        random_lookups(50, 1'b1);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
